ram_port_ctrl: RTL and testbench

- Upstream requester stage for the 8-bit-address / 8-bit-data fake RAM peripheral (Ram8a8d2 class).
- Converts a valid/ready request stream of single-byte reads and writes into RAM port cycles.
- Returns read data on a valid/ready response channel with backpressure.
- Sits between the peripheral bus decoder and the RAM model; one outstanding read at a time.

---
 rtl/ram_port_pkg.sv | 18 +
 rtl/ram_port_rsp_buf.sv | 37 +++
 rtl/ram_port_ctrl.sv | 138 +++++++++++++
 tb/tb_ram_port_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_pkg.sv
// Shared types and constants for the RAM port controller.
package ram_port_pkg;

  localparam int unsigned DefAddrW = 8;
  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefRdLat = 1;
  localparam int unsigned MaxRdLat = 4;
  localparam int unsigned LatCntW  = $clog2(MaxRdLat) + 1;

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StRdIssue,
    StRdWait,
    StRsp
  } state_e;

endpackage

// File: rtl/ram_port_rsp_buf.sv
// Response holding register: keeps valid/data stable until the consumer handshake.
module ram_port_rsp_buf
  import ram_port_pkg::*;
#(
  parameter int unsigned DataW = DefDataW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [DataW-1:0] load_data_i,
  input  logic             rdy_i,
  output logic             vld_o,
  output logic [DataW-1:0] data_o
);

  logic             vld_q;
  logic [DataW-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (en_i) begin
      if (load_i) begin
        vld_q  <= 1'b1;
        data_q <= load_data_i;
      end else if (vld_q && rdy_i) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/ram_port_ctrl.sv
// Request-to-RAM-port controller, one outstanding read. Define RAM_PORT_CLEAR_EN to zero
// the whole RAM after every reset before accepting requests.
module ram_port_ctrl
  import ram_port_pkg::*;
#(
  parameter int unsigned CAddrW = DefAddrW,
  parameter int unsigned CDataW = DefDataW,
  parameter int unsigned CRdLat = DefRdLat
) (
  input  logic              AClkH,
  input  logic              AResetH,
  input  logic              AClkHEn,
  input  logic              AReqVld,
  output logic              AReqRdy,
  input  logic              AReqWr,
  input  logic [CAddrW-1:0] AReqAddr,
  input  logic [CDataW-1:0] AReqData,
  output logic              ARspVld,
  input  logic              ARspRdy,
  output logic [CDataW-1:0] ARspData,
  output logic [CAddrW-1:0] ARamAddrWr,
  output logic [CAddrW-1:0] ARamAddrRd,
  output logic [CDataW-1:0] ARamMosi,
  input  logic [CDataW-1:0] ARamMiso,
  output logic              ARamWrEn,
  output logic              ABusy
);

  state_e              state_q;
  logic [LatCntW-1:0]  lat_cnt_q;
  logic                req_rdy_q;
  logic                wr_en_q;
  logic                busy_q;
  logic [CAddrW-1:0]   addr_wr_q;
  logic [CAddrW-1:0]   addr_rd_q;
  logic [CDataW-1:0]   mosi_q;
  logic                rsp_vld;
  logic                rsp_load;
  logic                req_fire;
  logic                rsp_fire;
`ifdef RAM_PORT_CLEAR_EN
  logic [CAddrW-1:0]   clr_addr_q;
`endif

  assign req_fire = AClkHEn & AReqVld & req_rdy_q;
  assign rsp_fire = AClkHEn & rsp_vld & ARspRdy;
  // Counter reaching zero on this edge means ARamMiso is valid now.
  assign rsp_load = AClkHEn && (state_q == StRdWait) && (lat_cnt_q == LatCntW'(1));

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
`ifdef RAM_PORT_CLEAR_EN
      state_q    <= StClear;
      req_rdy_q  <= 1'b0;
      busy_q     <= 1'b1;
      clr_addr_q <= '0;
`else
      state_q    <= StIdle;
      req_rdy_q  <= 1'b1;
      busy_q     <= 1'b0;
`endif
      lat_cnt_q  <= '0;
      wr_en_q    <= 1'b0;
      addr_wr_q  <= '0;
      addr_rd_q  <= '0;
      mosi_q     <= '0;
    end else if (AClkHEn) begin
      wr_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_fire) begin
            if (AReqWr) begin
              addr_wr_q <= AReqAddr;
              mosi_q    <= AReqData;
              wr_en_q   <= 1'b1;
            end else begin
              addr_rd_q <= AReqAddr;
              req_rdy_q <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= StRdIssue;
            end
          end
        end
        StRdIssue: begin
          lat_cnt_q <= LatCntW'(CRdLat);
          state_q   <= StRdWait;
        end
        StRdWait: begin
          lat_cnt_q <= lat_cnt_q - LatCntW'(1);
          if (lat_cnt_q == LatCntW'(1)) state_q <= StRsp;
        end
        StRsp: begin
          if (rsp_fire) begin
            req_rdy_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= StIdle;
          end
        end
`ifdef RAM_PORT_CLEAR_EN
        StClear: begin
          addr_wr_q  <= clr_addr_q;
          mosi_q     <= '0;
          wr_en_q    <= 1'b1;
          clr_addr_q <= clr_addr_q + CAddrW'(1);
          if (clr_addr_q == '1) begin
            req_rdy_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= StIdle;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  ram_port_rsp_buf #(
    .DataW (CDataW)
  ) u_rsp_buf (
    .clk_i       (AClkH),
    .rst_i       (AResetH),
    .en_i        (AClkHEn),
    .load_i      (rsp_load),
    .load_data_i (ARamMiso),
    .rdy_i       (ARspRdy),
    .vld_o       (rsp_vld),
    .data_o      (ARspData)
  );

  assign ARspVld    = rsp_vld;
  assign AReqRdy    = req_rdy_q;
  assign ARamAddrWr = addr_wr_q;
  assign ARamAddrRd = addr_rd_q;
  assign ARamMosi   = mosi_q;
  assign ARamWrEn   = wr_en_q;
  assign ABusy      = busy_q;

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Self-checking bench for ram_port_ctrl with a 1-cycle RAM model and an array reference.
module tb_ram_port_ctrl;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 8;
  localparam int unsigned LAT = 1;

  logic          AClkH = 1'b0;
  logic          AResetH, AClkHEn, AReqVld, AReqRdy, AReqWr;
  logic [AW-1:0] AReqAddr;
  logic [DW-1:0] AReqData;
  logic          ARspVld, ARspRdy;
  logic [DW-1:0] ARspData;
  logic [AW-1:0] ARamAddrWr, ARamAddrRd;
  logic [DW-1:0] ARamMosi, ARamMiso;
  logic          ARamWrEn, ABusy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] ram_mem [256];

  ram_port_ctrl #(
    .CAddrW (AW),
    .CDataW (DW),
    .CRdLat (LAT)
  ) dut (
    .AClkH      (AClkH),
    .AResetH    (AResetH),
    .AClkHEn    (AClkHEn),
    .AReqVld    (AReqVld),
    .AReqRdy    (AReqRdy),
    .AReqWr     (AReqWr),
    .AReqAddr   (AReqAddr),
    .AReqData   (AReqData),
    .ARspVld    (ARspVld),
    .ARspRdy    (ARspRdy),
    .ARspData   (ARspData),
    .ARamAddrWr (ARamAddrWr),
    .ARamAddrRd (ARamAddrRd),
    .ARamMosi   (ARamMosi),
    .ARamMiso   (ARamMiso),
    .ARamWrEn   (ARamWrEn),
    .ABusy      (ABusy)
  );

  always #5 AClkH = ~AClkH;

  // RAM peripheral: write on strobe, registered read one cycle after the address.
  always @(posedge AClkH) begin
    if (ARamWrEn) ram_mem[ARamAddrWr] <= ARamMosi;
    ARamMiso <= ram_mem[ARamAddrRd];
  end

  task automatic tick();
    @(posedge AClkH);
    #1;
  endtask

  // Holds a request until an edge accepts it; returns one cycle after acceptance.
  task automatic send_req(input bit wr, input logic [7:0] addr, input logic [7:0] data,
                          input bit rnd_en, output bit ok);
    ok = 1'b0;
    AReqVld = 1'b1; AReqWr = wr; AReqAddr = addr; AReqData = data;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (rnd_en) AClkHEn = ($urandom_range(0, 3) != 0);
      ok = AReqRdy && AClkHEn;
      tick();
    end
    AReqVld = 1'b0;
  endtask

  task automatic test_reset();
    bit exp_rdy, exp_busy, ok;
    int cnt;
`ifdef RAM_PORT_CLEAR_EN
    exp_rdy = 1'b0; exp_busy = 1'b1;
`else
    exp_rdy = 1'b1; exp_busy = 1'b0;
`endif
    AResetH = 1'b1;
    tick(); tick();
    n_checks++;
    if (AReqRdy !== exp_rdy) $display("FAIL reset_rdy: got %b want %b", AReqRdy, exp_rdy);
    else n_pass++;
    n_checks++;
    if (ARspVld !== 1'b0) $display("FAIL reset_rspvld: got %b want 0", ARspVld);
    else n_pass++;
    n_checks++;
    if (ARamWrEn !== 1'b0) $display("FAIL reset_wren: got %b want 0", ARamWrEn);
    else n_pass++;
    n_checks++;
    if (ABusy !== exp_busy) $display("FAIL reset_busy: got %b want %b", ABusy, exp_busy);
    else n_pass++;
    n_checks++;
    if ({ARamAddrWr, ARamAddrRd, ARamMosi, ARspData} !== 32'h0)
      $display("FAIL reset_data: got %h want 0", {ARamAddrWr, ARamAddrRd, ARamMosi, ARspData});
    else n_pass++;
    AResetH = 1'b0;
`ifdef RAM_PORT_CLEAR_EN
    cnt = 0;
    while (!AReqRdy && cnt < 400) begin tick(); cnt++; end
    n_checks++;
    if (cnt !== 256) $display("FAIL clear_len: got %0d want 256", cnt);
    else n_pass++;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      send_req(1'b0, (k == 0) ? 8'h00 : 8'hFF, 8'h00, 1'b0, ok);
      cnt = 0;
      while (!ARspVld && cnt < 50) begin tick(); cnt++; end
      n_checks++;
      if (!ok || ARspData !== 8'h00) $display("FAIL clear_read: got %h want 00", ARspData);
      else n_pass++;
      tick();
    end
`else
    tick();
    n_checks++;
    if (AReqRdy !== 1'b1) $display("FAIL reset_rdy_after: got %b want 1", AReqRdy);
    else n_pass++;
`endif
  endtask

  task automatic test_write_read();
    bit ok;
    int lat;
    send_req(1'b1, 8'h10, 8'hA5, 1'b0, ok);
    n_checks++;
    if (!ok || ARamWrEn !== 1'b1 || ARamAddrWr !== 8'h10 || ARamMosi !== 8'hA5)
      $display("FAIL wr_pulse: got en=%b a=%h d=%h want 1 10 a5", ARamWrEn, ARamAddrWr, ARamMosi);
    else n_pass++;
    ref_mem[8'h10] = 8'hA5;
    send_req(1'b0, 8'h10, 8'h00, 1'b0, ok);
    n_checks++;
    if (!ok || ARamWrEn !== 1'b0 || AReqRdy !== 1'b0 || ABusy !== 1'b1 || ARamAddrRd !== 8'h10)
      $display("FAIL rd_issue: got en=%b rdy=%b busy=%b a=%h want 0 0 1 10",
               ARamWrEn, AReqRdy, ABusy, ARamAddrRd);
    else n_pass++;
    lat = 1;
    while (!ARspVld && lat < 50) begin tick(); lat++; end
    n_checks++;
    if (lat !== 3) $display("FAIL rd_latency: got %0d want 3", lat);
    else n_pass++;
    n_checks++;
    if (ARspData !== ref_mem[8'h10])
      $display("FAIL rd_data: got %h want %h", ARspData, ref_mem[8'h10]);
    else n_pass++;
    tick();
    n_checks++;
    if (ARspVld !== 1'b0 || AReqRdy !== 1'b1 || ABusy !== 1'b0)
      $display("FAIL rsp_done: got vld=%b rdy=%b busy=%b want 0 1 0", ARspVld, AReqRdy, ABusy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d [4];
    for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
    AReqVld = 1'b1; AReqWr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      AReqAddr = 8'(i); AReqData = d[i];
      n_checks++;
      if (AReqRdy !== 1'b1) $display("FAIL b2b_rdy%0d: got %b want 1", i, AReqRdy);
      else n_pass++;
      tick();
      n_checks++;
      if (ARamWrEn !== 1'b1 || ARamAddrWr !== 8'(i) || ARamMosi !== d[i])
        $display("FAIL b2b_wr%0d: got en=%b a=%h d=%h want 1 %h %h",
                 i, ARamWrEn, ARamAddrWr, ARamMosi, 8'(i), d[i]);
      else n_pass++;
      ref_mem[i] = d[i];
    end
    AReqVld = 1'b0;
    tick();
    n_checks++;
    if (ARamWrEn !== 1'b0) $display("FAIL b2b_idle_wren: got %b want 0", ARamWrEn);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok, bad;
    int lat;
    ARspRdy = 1'b0;
    send_req(1'b0, 8'h01, 8'h00, 1'b0, ok);
    lat = 1;
    while (!ARspVld && lat < 50) begin tick(); lat++; end
    n_checks++;
    if (!ok || lat !== 3 || ARspData !== ref_mem[1])
      $display("FAIL bp_first: got lat=%0d d=%h want 3 %h", lat, ARspData, ref_mem[1]);
    else n_pass++;
    AReqVld = 1'b1; AReqWr = 1'b1; AReqAddr = 8'h20; AReqData = 8'h5A;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ARspVld !== 1'b1 || ARspData !== ref_mem[1] || AReqRdy !== 1'b0 || ARamWrEn !== 1'b0)
        bad = 1'b1;
      tick();
    end
    n_checks++;
    if (bad) $display("FAIL bp_hold: got unstable response or accept, want held");
    else n_pass++;
    ARspRdy = 1'b1;
    tick();
    n_checks++;
    if (ARspVld !== 1'b0 || AReqRdy !== 1'b1 || ARamWrEn !== 1'b0)
      $display("FAIL bp_release: got vld=%b rdy=%b en=%b want 0 1 0", ARspVld, AReqRdy, ARamWrEn);
    else n_pass++;
    tick();
    n_checks++;
    if (ARamWrEn !== 1'b1 || ARamAddrWr !== 8'h20 || ARamMosi !== 8'h5A)
      $display("FAIL bp_next_req: got en=%b a=%h d=%h want 1 20 5a", ARamWrEn, ARamAddrWr, ARamMosi);
    else n_pass++;
    AReqVld = 1'b0;
    ref_mem[8'h20] = 8'h5A;
  endtask

  task automatic test_clken();
    bit ok, bad;
    int lat;
    send_req(1'b0, 8'h20, 8'h00, 1'b0, ok);
    tick();
    lat = 2;
    AClkHEn = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); lat++;
      if (ARspVld !== 1'b0 || ABusy !== 1'b1) bad = 1'b1;
    end
    AClkHEn = 1'b1;
    n_checks++;
    if (!ok || bad) $display("FAIL clken_freeze: got ok=%b bad=%b want 1 0", ok, bad);
    else n_pass++;
    while (!ARspVld && lat < 50) begin tick(); lat++; end
    n_checks++;
    if (lat !== 6) $display("FAIL clken_latency: got %0d want 6", lat);
    else n_pass++;
    n_checks++;
    if (ARspData !== ref_mem[8'h20])
      $display("FAIL clken_data: got %h want %h", ARspData, ref_mem[8'h20]);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_read();
    bit ok, bad;
    int cnt;
    send_req(1'b0, 8'h02, 8'h00, 1'b0, ok);
    tick();
    AResetH = 1'b1;
    tick();
    AResetH = 1'b0;
    n_checks++;
`ifdef RAM_PORT_CLEAR_EN
    if (!ok || ARspVld !== 1'b0 || AReqRdy !== 1'b0 || ARamWrEn !== 1'b0)
`else
    if (!ok || ARspVld !== 1'b0 || AReqRdy !== 1'b1 || ARamWrEn !== 1'b0)
`endif
      $display("FAIL rst_mid_read: got vld=%b rdy=%b en=%b", ARspVld, AReqRdy, ARamWrEn);
    else n_pass++;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ARspVld !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) $display("FAIL rst_no_rsp: got response after reset, want none");
    else n_pass++;
`ifdef RAM_PORT_CLEAR_EN
    cnt = 0;
    while (!AReqRdy && cnt < 400) begin tick(); cnt++; end
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
`else
    cnt = 0;
`endif
  endtask

  task automatic test_random();
    bit ok, bad, fire;
    int n_en, guard;
    logic [7:0] a, d;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      send_req(1'b1, 8'(i), d, 1'b1, ok);
      if (ok) ref_mem[i] = d;
    end
    for (int t = 0; t < 60; t++) begin
      a = 8'($urandom_range(0, 15));
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        send_req(1'b1, a, d, 1'b1, ok);
        n_checks++;
        if (!ok || ARamWrEn !== 1'b1 || ARamAddrWr !== a || ARamMosi !== d)
          $display("FAIL rnd_wr%0d: got en=%b a=%h d=%h want 1 %h %h",
                   t, ARamWrEn, ARamAddrWr, ARamMosi, a, d);
        else n_pass++;
        ref_mem[a] = d;
      end else begin
        send_req(1'b0, a, 8'h00, 1'b1, ok);
        n_en = 0;
        guard = 0;
        while (!ARspVld && guard < 50) begin
          AClkHEn = ($urandom_range(0, 3) != 0);
          if (AClkHEn) n_en++;
          tick(); guard++;
        end
        n_checks++;
        if (!ok || n_en !== 2 || ARspData !== ref_mem[a])
          $display("FAIL rnd_rd%0d: got en_cyc=%0d d=%h want 2 %h", t, n_en, ARspData, ref_mem[a]);
        else n_pass++;
        bad = 1'b0;
        fire = 1'b0;
        guard = 0;
        while (!fire && guard < 50) begin
          AClkHEn = ($urandom_range(0, 3) != 0);
          ARspRdy = ($urandom_range(0, 1) == 1);
          fire = AClkHEn && ARspRdy;
          if (ARspVld !== 1'b1 || ARspData !== ref_mem[a]) bad = 1'b1;
          tick(); guard++;
        end
        ARspRdy = 1'b1;
        n_checks++;
        if (bad || !fire || ARspVld !== 1'b0 || AReqRdy !== 1'b1)
          $display("FAIL rnd_rsp%0d: got bad=%b vld=%b rdy=%b want 0 0 1", t, bad, ARspVld, AReqRdy);
        else n_pass++;
      end
    end
    AClkHEn = 1'b1;
    tick();
  endtask

  initial begin
    AResetH = 1'b1; AClkHEn = 1'b1; AReqVld = 1'b0; AReqWr = 1'b0;
    AReqAddr = '0; AReqData = '0; ARspRdy = 1'b1;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_clken();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
